// File: rtl/regfile_rename.sv
// Architectural register file with a rename (register-status) table.
// Reads return the committed value or the pending ROB tag, with same-cycle commit forwarding.
module regfile_rename_rdport #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ROB_WIDTH      = 4
) (
  input  logic [REG_ADDR_WIDTH-1:0]                 i_addr,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]      i_value,
  input  logic [REG_COUNT-1:0]                      i_busy,
  input  logic [REG_COUNT-1:0][ROB_WIDTH-1:0]       i_reorder,
  input  logic                                      i_commit_vld,
  input  logic [REG_ADDR_WIDTH-1:0]                 i_commit_rd,
  input  logic [ROB_WIDTH-1:0]                      i_commit_reorder,
  input  logic [DATA_WIDTH-1:0]                     i_commit_value,
  output logic                                      o_busy,
  output logic [DATA_WIDTH-1:0]                     o_value,
  output logic [ROB_WIDTH-1:0]                      o_reorder
);
  localparam logic [REG_ADDR_WIDTH:0] LP_CNT = (REG_ADDR_WIDTH+1)'(REG_COUNT);

  logic w_valid;
  logic w_fwd;

  assign w_valid = (i_addr != '0) && ({1'b0, i_addr} < LP_CNT);
  // Forward only a commit that actually retires the pending producer.
  assign w_fwd   = i_commit_vld && (i_commit_rd == i_addr) && i_busy[i_addr] &&
                   (i_reorder[i_addr] == i_commit_reorder);

  always_comb begin
    o_busy    = 1'b0;
    o_value   = '0;
    o_reorder = '0;
    if (w_valid) begin
      o_reorder = i_reorder[i_addr];
      if (w_fwd) begin
        o_value = i_commit_value;
      end else begin
        o_busy  = i_busy[i_addr];
        o_value = i_value[i_addr];
      end
    end
  end
endmodule

module regfile_rename #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ROB_WIDTH      = 4,
  parameter int READ_PORTS     = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 rdy_in,
  input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] rd_addr_in,
  output logic [READ_PORTS-1:0]                rd_busy_out,
  output logic [READ_PORTS*DATA_WIDTH-1:0]     rd_value_out,
  output logic [READ_PORTS*ROB_WIDTH-1:0]      rd_reorder_out,
  input  logic                                 dispatch_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]            dispatch_rd_in,
  input  logic [ROB_WIDTH-1:0]                 dispatch_reorder_in,
  input  logic                                 commit_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]            commit_rd_in,
  input  logic [ROB_WIDTH-1:0]                 commit_reorder_in,
  input  logic [DATA_WIDTH-1:0]                commit_value_in,
  input  logic                                 flush_in
);
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] r_value;
  logic [REG_COUNT-1:0]                 r_busy;
  logic [REG_COUNT-1:0][ROB_WIDTH-1:0]  r_reorder;
  logic                                 w_commit_vld;

  assign w_commit_vld = commit_en_in && rdy_in;

  genvar k;
  generate
    for (k = 0; k < READ_PORTS; k++) begin : g_rd
      regfile_rename_rdport #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_COUNT     (REG_COUNT),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .ROB_WIDTH     (ROB_WIDTH)
      ) u_rd (
        .i_addr          (rd_addr_in[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
        .i_value         (r_value),
        .i_busy          (r_busy),
        .i_reorder       (r_reorder),
        .i_commit_vld    (w_commit_vld),
        .i_commit_rd     (commit_rd_in),
        .i_commit_reorder(commit_reorder_in),
        .i_commit_value  (commit_value_in),
        .o_busy          (rd_busy_out[k]),
        .o_value         (rd_value_out[k*DATA_WIDTH +: DATA_WIDTH]),
        .o_reorder       (rd_reorder_out[k*ROB_WIDTH +: ROB_WIDTH])
      );
    end
  endgenerate

  // Register 0 is never written, so it stays zero / not busy from reset.
  // Statement order encodes priority: dispatch overrides commit's busy clear,
  // flush overrides both, and flush discards the dispatch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_value   <= '0;
      r_busy    <= '0;
      r_reorder <= '0;
    end else if (rdy_in) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (commit_en_in && (commit_rd_in == REG_ADDR_WIDTH'(i))) begin
          r_value[i] <= commit_value_in;
          if (r_reorder[i] == commit_reorder_in) r_busy[i] <= 1'b0;
        end
        if (flush_in) begin
          r_busy[i] <= 1'b0;
        end else if (dispatch_en_in && (dispatch_rd_in == REG_ADDR_WIDTH'(i))) begin
          r_busy[i]    <= 1'b1;
          r_reorder[i] <= dispatch_reorder_in;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: vector table plus async-reset sequences.
module tb_regfile_rename;
  localparam int DW = 32, RC = 32, AW = 5, TW = 4, RP = 2;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           rdy_in;
  logic [RP*AW-1:0] rd_addr_in;
  logic [RP-1:0]    rd_busy_out;
  logic [RP*DW-1:0] rd_value_out;
  logic [RP*TW-1:0] rd_reorder_out;
  logic           dispatch_en_in;
  logic [AW-1:0]  dispatch_rd_in;
  logic [TW-1:0]  dispatch_reorder_in;
  logic           commit_en_in;
  logic [AW-1:0]  commit_rd_in;
  logic [TW-1:0]  commit_reorder_in;
  logic [DW-1:0]  commit_value_in;
  logic           flush_in;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_rename #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .REG_ADDR_WIDTH(AW), .ROB_WIDTH(TW), .READ_PORTS(RP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_addr_in(rd_addr_in), .rd_busy_out(rd_busy_out),
    .rd_value_out(rd_value_out), .rd_reorder_out(rd_reorder_out),
    .dispatch_en_in(dispatch_en_in), .dispatch_rd_in(dispatch_rd_in),
    .dispatch_reorder_in(dispatch_reorder_in),
    .commit_en_in(commit_en_in), .commit_rd_in(commit_rd_in),
    .commit_reorder_in(commit_reorder_in), .commit_value_in(commit_value_in),
    .flush_in(flush_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          de;  logic [AW-1:0] drd; logic [TW-1:0] dtag;
    logic          ce;  logic [AW-1:0] crd; logic [TW-1:0] ctag; logic [DW-1:0] cval;
    logic          fl;  logic          rdy;
    logic [AW-1:0] a0;  logic [AW-1:0] a1;
    logic          eb0; logic [DW-1:0] ev0; logic [TW-1:0] et0;
    logic          eb1; logic [DW-1:0] ev1; logic [TW-1:0] et1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic de, input int drd, input int dtag,
    input logic ce, input int crd, input int ctag, input logic [DW-1:0] cval,
    input logic fl, input logic rdy, input int a0, input int a1,
    input logic eb0, input logic [DW-1:0] ev0, input int et0,
    input logic eb1, input logic [DW-1:0] ev1, input int et1);
    vec_t v;
    v.de = de; v.drd = AW'(drd); v.dtag = TW'(dtag);
    v.ce = ce; v.crd = AW'(crd); v.ctag = TW'(ctag); v.cval = cval;
    v.fl = fl; v.rdy = rdy; v.a0 = AW'(a0); v.a1 = AW'(a1);
    v.eb0 = eb0; v.ev0 = ev0; v.et0 = TW'(et0);
    v.eb1 = eb1; v.ev1 = ev1; v.et1 = TW'(et1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Tag is only meaningful while busy, so it is compared only then.
  task automatic chk_port(input string tag, input int k,
                          input logic eb, input logic [DW-1:0] ev, input logic [TW-1:0] et);
    chk({tag, $sformatf(" p%0d busy", k)}, DW'(rd_busy_out[k]), DW'(eb));
    chk({tag, $sformatf(" p%0d value", k)}, rd_value_out[k*DW +: DW], ev);
    if (eb) chk({tag, $sformatf(" p%0d tag", k)}, DW'(rd_reorder_out[k*TW +: TW]), DW'(et));
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; dispatch_en_in = 1'b0; dispatch_rd_in = '0; dispatch_reorder_in = '0;
    commit_en_in = 1'b0; commit_rd_in = '0; commit_reorder_in = '0; commit_value_in = '0;
    flush_in = 1'b0;
  endtask

  initial begin
    // de drd dtag | ce crd ctag cval | fl rdy | a0 a1 | eb0 ev0 et0 | eb1 ev1 et1
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 5,5, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(0,0,0, 1,5,3,32'h1234, 0,1, 5,5, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 5,0, 0,32'h1234,0, 0,32'h0,0));
    vecs.push_back(mk(1,3,7, 0,0,0,32'h0,    0,1, 3,3, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 3,5, 1,32'h0,7,    0,32'h1234,0));
    vecs.push_back(mk(0,0,0, 1,3,7,32'hAA,   0,1, 3,5, 0,32'hAA,0,   0,32'h1234,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 3,3, 0,32'hAA,0,   0,32'hAA,0));
    vecs.push_back(mk(1,3,2, 0,0,0,32'h0,    0,1, 3,3, 0,32'hAA,0,   0,32'hAA,0));
    vecs.push_back(mk(1,3,9, 0,0,0,32'h0,    0,1, 3,3, 1,32'hAA,2,   1,32'hAA,2));
    vecs.push_back(mk(0,0,0, 1,3,2,32'h11,   0,1, 3,3, 1,32'hAA,9,   1,32'hAA,9));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 3,3, 1,32'h11,9,   1,32'h11,9));
    vecs.push_back(mk(0,0,0, 1,3,9,32'h22,   0,1, 3,3, 0,32'h22,0,   0,32'h22,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 3,3, 0,32'h22,0,   0,32'h22,0));
    vecs.push_back(mk(1,4,1, 0,0,0,32'h0,    0,1, 4,4, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(1,4,1, 1,4,1,32'h55,   0,1, 4,4, 0,32'h55,0,   0,32'h55,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 4,3, 1,32'h55,1,   0,32'h22,0));
    vecs.push_back(mk(1,1,1, 0,0,0,32'h0,    0,1, 1,2, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(1,2,2, 0,0,0,32'h0,    0,1, 1,2, 1,32'h0,1,    0,32'h0,0));
    vecs.push_back(mk(1,6,6, 0,0,0,32'h0,    0,1, 1,2, 1,32'h0,1,    1,32'h0,2));
    vecs.push_back(mk(1,7,3, 1,2,2,32'h77,   1,1, 2,6, 0,32'h77,0,   1,32'h0,6));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 1,6, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 7,2, 0,32'h0,0,    0,32'h77,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 4,3, 0,32'h55,0,   0,32'h22,0));
    vecs.push_back(mk(1,0,5, 1,0,0,32'hFF,   0,1, 0,0, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 0,0, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(1,8,4, 1,3,0,32'h99,   0,0, 8,3, 0,32'h0,0,    0,32'h22,0));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 8,3, 0,32'h0,0,    0,32'h22,0));
    vecs.push_back(mk(1,9,5, 0,0,0,32'h0,    0,1, 9,9, 0,32'h0,0,    0,32'h0,0));
    vecs.push_back(mk(0,0,0, 1,9,5,32'h33,   0,0, 9,9, 1,32'h0,5,    1,32'h0,5));
    vecs.push_back(mk(0,0,0, 0,0,0,32'h0,    0,1, 9,9, 1,32'h0,5,    1,32'h0,5));

    idle_inputs();
    rst_in = 1'b1;
    rd_addr_in = {AW'(5), AW'(5)};
    #3;
    chk_port("reset x5", 0, 1'b0, 32'h0, 4'h0);
    chk_port("reset x5", 1, 1'b0, 32'h0, 4'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      dispatch_en_in = vecs[i].de; dispatch_rd_in = vecs[i].drd; dispatch_reorder_in = vecs[i].dtag;
      commit_en_in = vecs[i].ce; commit_rd_in = vecs[i].crd; commit_reorder_in = vecs[i].ctag;
      commit_value_in = vecs[i].cval; flush_in = vecs[i].fl; rdy_in = vecs[i].rdy;
      rd_addr_in = {vecs[i].a1, vecs[i].a0};
      #4;
      chk_port($sformatf("vec%0d", i), 0, vecs[i].eb0, vecs[i].ev0, vecs[i].et0);
      chk_port($sformatf("vec%0d", i), 1, vecs[i].eb1, vecs[i].ev1, vecs[i].et1);
      @(posedge clk_in); #1;
    end

    // Async reset between edges: x9 busy tag 5, x3 = 0x22 must clear with no edge.
    idle_inputs();
    rd_addr_in = {AW'(3), AW'(9)};
    #1;
    chk_port("pre-rst x9", 0, 1'b1, 32'h0, 4'h5);
    chk_port("pre-rst x3", 1, 1'b0, 32'h22, 4'h0);
    rst_in = 1'b1;
    #1;
    chk_port("async rst x9", 0, 1'b0, 32'h0, 4'h0);
    chk_port("async rst x3", 1, 1'b0, 32'h0, 4'h0);

    // Reset held across an edge overrides a concurrent dispatch and commit.
    dispatch_en_in = 1'b1; dispatch_rd_in = AW'(9); dispatch_reorder_in = 4'h6;
    commit_en_in = 1'b1; commit_rd_in = AW'(3); commit_reorder_in = 4'h0; commit_value_in = 32'hBEEF;
    @(posedge clk_in); #1;
    idle_inputs();
    #1;
    chk_port("rst held x9", 0, 1'b0, 32'h0, 4'h0);
    chk_port("rst held x3", 1, 1'b0, 32'h0, 4'h0);
    rst_in = 1'b0;

    // After release, normal commit resumes.
    commit_en_in = 1'b1; commit_rd_in = AW'(3); commit_value_in = 32'h5A5A;
    @(posedge clk_in); #1;
    idle_inputs();
    #1;
    chk_port("post-rst x3", 1, 1'b0, 32'h5A5A, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
